// File: rtl/cpu_pkg.sv
// Shared CPU-side types: addressing modes and the operand-fetch sequencer states.
package cpu_pkg;

    typedef enum logic [1:0] {
        IMM   = 2'b00,
        DIR   = 2'b01,
        INDIR = 2'b10,
        REG   = 2'b11
    } addr_mode_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REG_RD  = 3'd1,
        S_REG_CAP = 3'd2,
        S_MEM_RD  = 3'd3,
        S_DONE    = 3'd4
    } ofc_state_e;

endpackage

// File: rtl/operand_fetch_ctrl.sv
// Operand fetch sequencer: resolves IMM/DIR/INDIR/REG operands through a
// synchronous regfile read port and a handshaked RAM read port.
module operand_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int MODE_WIDTH     = 2,
    parameter int OPERAND_WIDTH  = 8,
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int RAM_DATA_WIDTH = 8,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int REG_DATA_WIDTH = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [MODE_WIDTH-1:0]     mode,
    input  logic [OPERAND_WIDTH-1:0]  operand_in,
    input  logic                      abort,
    output logic                      ready,
    output logic                      valid,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      err,
    output logic                      reg_rd_en,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr,
    input  logic [REG_DATA_WIDTH-1:0] reg_data,
    output logic                      ram_rd_req,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    input  logic                      ram_rd_ack,
    input  logic [RAM_DATA_WIDTH-1:0] ram_data
);

    localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int XA  = (OPERAND_WIDTH > REG_DATA_WIDTH) ? OPERAND_WIDTH : REG_DATA_WIDTH;
    localparam int XB  = (RAM_DATA_WIDTH > DATA_WIDTH) ? RAM_DATA_WIDTH : DATA_WIDTH;
    localparam int XC  = (XA > XB) ? XA : XB;
    localparam int XW  = (XC > RAM_ADDR_WIDTH) ? XC : RAM_ADDR_WIDTH;

    ofc_state_e                state_q, state_d;
    addr_mode_e                mode_q, mode_d;
    logic [OPERAND_WIDTH-1:0]  op_q, op_d;
    logic [REG_DATA_WIDTH-1:0] tmp_q, tmp_d;
    logic [DATA_WIDTH-1:0]     res_q, res_d;
    logic [DATA_WIDTH-1:0]     data_out_q, data_out_d;
    logic [CW-1:0]             wait_q, wait_d;
    logic                      err_q, err_d;

    // Zero-extended views of every source; slicing these gives the
    // unsigned extend/truncate behaviour at each destination.
    logic [XW-1:0] opin_x, op_x, tmp_x, regd_x, ramd_x;
    addr_mode_e    mode_in;

    // Width adaptation of sources to a common wide vector
    always_comb begin
        opin_x = '0;
        op_x   = '0;
        tmp_x  = '0;
        regd_x = '0;
        ramd_x = '0;
        opin_x[OPERAND_WIDTH-1:0]  = operand_in;
        op_x[OPERAND_WIDTH-1:0]    = op_q;
        tmp_x[REG_DATA_WIDTH-1:0]  = tmp_q;
        regd_x[REG_DATA_WIDTH-1:0] = reg_data;
        ramd_x[RAM_DATA_WIDTH-1:0] = ram_data;
    end

    assign mode_in = addr_mode_e'(mode[1:0]);

    // Next-state and datapath register update
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        op_d       = op_q;
        tmp_d      = tmp_q;
        res_d      = res_q;
        data_out_d = data_out_q;
        wait_d     = wait_q;
        err_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // abort alongside start drops the request
                if (start && !abort) begin
                    mode_d = mode_in;
                    op_d   = operand_in;
                    wait_d = '0;
                    unique case (mode_in)
                        IMM: begin
                            res_d   = opin_x[DATA_WIDTH-1:0];
                            state_d = S_DONE;
                        end
                        DIR:        state_d = S_MEM_RD;
                        INDIR, REG: state_d = S_REG_RD;
                        default:    state_d = S_IDLE;
                    endcase
                end
            end
            S_REG_RD: state_d = S_REG_CAP;
            S_REG_CAP: begin
                tmp_d = reg_data;
                if (mode_q == REG) begin
                    res_d   = regd_x[DATA_WIDTH-1:0];
                    state_d = S_DONE;
                end else begin
                    wait_d  = '0;
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                if (ram_rd_ack) begin
                    res_d   = ramd_x[DATA_WIDTH-1:0];
                    state_d = S_DONE;
                end else if (wait_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DONE: begin
                data_out_d = res_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Flush overrides any completion, timeout or ack this cycle
        if (abort && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            err_d      = 1'b0;
            data_out_d = data_out_q;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= IMM;
            op_q       <= '0;
            tmp_q      <= '0;
            res_q      <= '0;
            data_out_q <= '0;
            wait_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            op_q       <= op_d;
            tmp_q      <= tmp_d;
            res_q      <= res_d;
            data_out_q <= data_out_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
        end
    end

    // Outputs are decoded from registered state; addresses come straight from
    // op/tmp registers so they stay stable for the whole request.
    assign ready      = (state_q == S_IDLE);
    assign valid      = (state_q == S_DONE) && !abort;
    assign data_out   = valid ? res_q : data_out_q;
    assign err        = err_q;
    assign reg_rd_en  = (state_q == S_REG_RD);
    assign reg_addr   = op_x[REG_ADDR_WIDTH-1:0];
    assign ram_rd_req = (state_q == S_MEM_RD);
    assign ram_addr   = (mode_q == INDIR) ? tmp_x[RAM_ADDR_WIDTH-1:0] : op_x[RAM_ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Bench for operand_fetch_ctrl: directed cases followed by random fetches
// checked against a latency/value model of the addressing modes.
module tb_operand_fetch_ctrl;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst, start, abort, ram_rd_ack;
    logic [1:0] mode;
    logic [7:0] operand_in, reg_data, ram_data;
    logic       ready, valid, err, reg_rd_en, ram_rd_req;
    logic [7:0] data_out, ram_addr;
    logic [3:0] reg_addr;

    logic [7:0] regf [16];
    logic [7:0] ram  [256];
    logic [7:0] held;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    operand_fetch_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .operand_in(operand_in),
        .abort(abort), .ready(ready), .valid(valid), .data_out(data_out), .err(err),
        .reg_rd_en(reg_rd_en), .reg_addr(reg_addr), .reg_data(reg_data),
        .ram_rd_req(ram_rd_req), .ram_addr(ram_addr), .ram_rd_ack(ram_rd_ack),
        .ram_data(ram_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // md: 0 IMM, 1 DIR, 2 INDIR, 3 REG. waits = un-acked RAM cycles before ack.
    // ab = cycle offset after accept at which abort is raised (0 = none).
    task automatic run_txn(input int md, input logic [7:0] opnd, input int waits, input int ab);
        bit regm, memm, errc, killed, prev_en, e_valid, e_err, e_reg, e_req;
        int mo, ev, last_req, idle_from, reqcnt;
        logic [7:0] e_val, e_raddr;
        logic [3:0] prev_addr;
        regm = (md == 2 || md == 3);
        memm = (md == 1 || md == 2);
        mo   = (md == 1) ? 1 : 3;
        e_raddr = (md == 1) ? opnd : regf[opnd[3:0]];
        case (md)
            0:       e_val = opnd;
            3:       e_val = regf[opnd[3:0]];
            default: e_val = ram[e_raddr];
        endcase
        errc = memm && (waits >= TO);
        if (md == 0)      ev = 1;
        else if (md == 3) ev = 3;
        else if (errc)    ev = mo + TO;
        else              ev = mo + waits + 1;
        last_req = errc ? mo + TO - 1 : mo + waits;
        if (ab > 0 && ab < (errc ? ev : ev + 1)) idle_from = ab + 1;
        else                                      idle_from = errc ? ev : ev + 1;
        reqcnt  = 0;
        prev_en = 1'b0;
        prev_addr = '0;

        step;
        start = 1'b1; mode = 2'(md); operand_in = opnd; abort = 1'b0;
        ram_rd_ack = 1'b0; reg_data = 8'($urandom); ram_data = 8'($urandom);
        #1;
        chk("ready_at_accept", ready, 1'b1);
        for (int c = 1; c <= idle_from; c++) begin
            step;
            start      = (c < idle_from) ? 1'($urandom_range(0, 1)) : 1'b0;
            mode       = 2'($urandom);
            operand_in = 8'($urandom);
            abort      = (c == ab);
            reg_data   = prev_en ? regf[prev_addr] : 8'($urandom);
            ram_rd_ack = ram_rd_req && (reqcnt == waits);
            ram_data   = ram_rd_ack ? ram[ram_addr] : 8'($urandom);
            if (ram_rd_req) reqcnt++;
            prev_en   = reg_rd_en;
            prev_addr = reg_addr;
            #1;
            killed  = (ab > 0) && (ab < c);
            e_valid = !errc && (c == ev) && !killed && (ab != c);
            e_err   = errc && (c == ev) && !killed;
            e_reg   = regm && (c == 1);
            e_req   = memm && (c >= mo) && (c <= last_req) && !killed;
            chk($sformatf("valid m%0d c%0d", md, c), valid, e_valid);
            chk($sformatf("err m%0d c%0d", md, c), err, e_err);
            chk($sformatf("ready m%0d c%0d", md, c), ready, (c >= idle_from));
            chk($sformatf("reg_rd_en m%0d c%0d", md, c), reg_rd_en, e_reg);
            chk($sformatf("ram_rd_req m%0d c%0d", md, c), ram_rd_req, e_req);
            if (e_reg) chk("reg_addr", reg_addr, opnd[3:0]);
            if (e_req) chk("ram_addr", ram_addr, e_raddr);
            chk($sformatf("data_out m%0d c%0d", md, c), data_out, e_valid ? e_val : held);
            if (e_valid) held = e_val;
        end
        start = 1'b0; abort = 1'b0; ram_rd_ack = 1'b0;
    endtask

    // Reset asserted while an INDIR fetch sits in MEM_RD
    task automatic rst_mid(input logic [7:0] opnd);
        step;
        start = 1'b1; mode = 2'd2; operand_in = opnd; abort = 1'b0; ram_rd_ack = 1'b0;
        #1;
        chk("rm_ready0", ready, 1'b1);
        step; start = 1'b0;
        step; reg_data = regf[opnd[3:0]];
        step; rst = 1'b1;
        #1;
        chk("rm_in_memrd", ram_rd_req, 1'b1);
        step; rst = 1'b0;
        #1;
        held = 8'h00;
        chk("rm_ready", ready, 1'b1);
        chk("rm_req", ram_rd_req, 1'b0);
        chk("rm_dout", data_out, 8'h00);
        chk("rm_raddr", ram_addr, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step;
            #1;
            chk("rm_valid", valid, 1'b0);
            chk("rm_err", err, 1'b0);
        end
    endtask

    initial begin
        int md, w, ab, ev;
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; operand_in = 8'h00;
        ram_rd_ack = 1'b0; reg_data = 8'h00; ram_data = 8'h00;
        held = 8'h00;
        for (int i = 0; i < 16; i++) regf[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        step; step;
        chk("rst_ready", ready, 1'b1);
        chk("rst_valid", valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_reg_en", reg_rd_en, 1'b0);
        chk("rst_ram_req", ram_rd_req, 1'b0);
        chk("rst_dout", data_out, 8'h00);
        chk("rst_reg_addr", reg_addr, 4'h0);
        chk("rst_ram_addr", ram_addr, 8'h00);
        rst = 1'b0;

        regf[3] = 8'hC4; regf[2] = 8'h40;
        ram[8'h20] = 8'h77; ram[8'h40] = 8'h99;
        run_txn(0, 8'h5A, 0, 0);
        run_txn(3, 8'h13, 0, 0);
        run_txn(1, 8'h20, 2, 0);
        run_txn(2, 8'h02, 0, 0);
        run_txn(1, 8'h20, 40, 0);
        run_txn(2, 8'h02, 0, 2);
        run_txn(0, 8'hA5, 0, 1);

        // abort together with start in IDLE drops the request
        step; start = 1'b1; mode = 2'd0; operand_in = 8'h3C; abort = 1'b1;
        step; start = 1'b0; abort = 1'b0;
        #1;
        chk("abs_ready", ready, 1'b1);
        chk("abs_valid", valid, 1'b0);
        chk("abs_dout", data_out, held);

        rst_mid(8'h02);

        for (int n = 0; n < 60; n++) begin
            md = $urandom_range(0, 3);
            w  = ($urandom_range(0, 4) == 0) ? $urandom_range(TO - 1, TO + 4) : $urandom_range(0, 4);
            if (md == 0)      ev = 1;
            else if (md == 3) ev = 3;
            else              ev = ((md == 1) ? 1 : 3) + ((w >= TO) ? TO : w + 1);
            ab = 0;
            if ($urandom_range(0, 3) == 0) begin
                if ((md == 1 || md == 2) && w >= TO) ab = $urandom_range(1, ev - 1);
                else                                 ab = $urandom_range(1, ev);
            end
            run_txn(md, 8'($urandom), w, ab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
